// File: rtl/nibble_addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit ripple add/subtract slice with a carry-in kept separate
// from the invert control so the carry can be chained across clock cycles.
module nibble_addsub_slice
  import nibble_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                inv,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] b_eff;
  logic [NIBBLE_W:0]   c;

  assign b_eff = b ^ {NIBBLE_W{inv}};

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b_eff[i] ^ c[i];
      c[i+1]   = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
    end
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_addsub_seq.sv
// Wide add/subtract executed one nibble per clock through a single 4-bit slice,
// LSB nibble first, with a valid/ready command port and a valid/ready result port.
module nibble_addsub_seq
  import nibble_addsub_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES,
  localparam int IDX_W   = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic                sub_q, sub_d;
  logic [W-1:0]        res_q, res_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout;

  // Signed overflow from operand and result sign bits; subtract flips the B sign test.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                    input logic r_msb, input logic sub);
    if (sub) return (a_msb != b_msb) && (r_msb != a_msb);
    else     return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  assign nib_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign nib_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  nibble_addsub_slice u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .inv  (sub_q),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = op_sub;
          idx_d   = '0;
          carry_d = op_sub;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_sum;
        carry_d = nib_cout;
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign result      = res_q;
  assign carry_out   = carry_q;
  assign overflow    = ovf_calc(a_q[W-1], b_q[W-1], res_q[W-1], sub_q);

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Self-checking bench for nibble_addsub_seq: arithmetic reference model plus a
// per-cycle handshake/latency checker, directed corner cases and random traffic.
module tb_nibble_addsub_seq;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  bit   post_rst = 1'b0;
  bit   busy;
  bit   exp_v;

  nibble_addsub_seq #(.NIBBLES(NIBBLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_sub      (op_sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   sa, sb, sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      e.r = a - b;
      e.c = (a >= b);
      sr  = sa - sb;
    end else begin
      e.r = a + b;
      e.c = ((int'(a) + int'(b)) >= (1 << W));
      sr  = sa + sb;
    end
    e.o = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        chk("rst_start_ready", start_ready, 1);
        chk("rst_res_valid",   res_valid,   0);
        chk("rst_result",      result,      0);
        chk("rst_carry_out",   carry_out,   0);
        chk("rst_overflow",    overflow,    0);
        post_rst = 1'b0;
      end
      busy  = (exp_q.size() > 0);
      chk("start_ready", start_ready, !busy);
      exp_v = busy && ((cyc - acc_q[0]) >= NIBBLES + 1);
      chk("res_valid", res_valid, exp_v);
      if (res_valid && busy) begin
        chk("result",    result,    exp_q[0].r);
        chk("carry_out", carry_out, exp_q[0].c);
        chk("overflow",  overflow,  exp_q[0].o);
        if (res_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
      if (start_valid && start_ready) begin
        exp_q.push_back(model(op_a, op_b, op_sub));
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic start_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    op_sub = s;
    while (!start_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!start_ready) chk("accept_timeout", start_ready, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    op_a = W'($urandom);
    op_b = W'($urandom);
    op_sub = 1'($urandom);
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 4 * NIBBLES) begin
      @(posedge clk); #1;
      n++;
    end
    if (!res_valid) chk("res_timeout", res_valid, 1);
  endtask

  task automatic finish_res(input int hold);
    repeat (hold) begin
      start_valid = 1'($urandom);
      op_a = W'($urandom);
      op_b = W'($urandom);
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] er, input logic ec, input logic eo);
    int n;
    start_cmd(a, b, s);
    wait_res(n);
    chk({name, "_result"}, result, er);
    chk({name, "_carry"},  carry_out, ec);
    chk({name, "_ovf"},    overflow, eo);
    finish_res(0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    exp_t e;
    int   n;
    logic [W-1:0] r0;

    rst = 1'b1;
    start_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    op_sub = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    e = model(16'h1234, 16'h0FCD, 1'b0); chk("model_add",   e, {16'h2201, 1'b0, 1'b0});
    e = model(16'h0005, 16'h0007, 1'b1); chk("model_borrow", e, {16'hFFFE, 1'b0, 1'b0});
    e = model(16'h7FFF, 16'h0001, 1'b0); chk("model_povf",  e, {16'h8000, 1'b0, 1'b1});
    e = model(16'h8000, 16'h0001, 1'b1); chk("model_novf",  e, {16'h7FFF, 1'b1, 1'b1});
    e = model(16'hFFFF, 16'h0001, 1'b0); chk("model_wrap",  e, {16'h0000, 1'b1, 1'b0});
    e = model(16'h1234, 16'h1234, 1'b1); chk("model_zero",  e, {16'h0000, 1'b1, 1'b0});

    @(posedge clk); #1;
    start_cmd(16'h1234, 16'h0FCD, 1'b0);
    wait_res(n);
    chk("add_latency", n, NIBBLES);
    chk("add_result", result, 16'h2201);
    chk("add_carry",  carry_out, 0);
    chk("add_ovf",    overflow, 0);
    finish_res(0);

    run_lit("borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_lit("povf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_lit("novf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_lit("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_lit("zero",   16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure with a competing command held on the start port.
    start_cmd(16'h1111, 16'h2222, 1'b0);
    wait_res(n);
    r0 = result;
    start_valid = 1'b1;
    op_a = 16'h9ABC;
    op_b = 16'h8001;
    op_sub = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid",  res_valid, 1);
      chk("bp_result", result, r0);
      chk("bp_ready",  start_ready, 0);
      chk("bp_ovf",    overflow, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_idle_ready", start_ready, 1);
    chk("bp_idle_valid", res_valid, 0);
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("bp_accepted", start_ready, 0);
    wait_res(n);
    chk("bp_new_result", result, 16'h1ABD);
    chk("bp_new_carry",  carry_out, 1);
    chk("bp_new_ovf",    overflow, 1);
    finish_res(0);

    // Abort during the second RUN cycle.
    start_cmd(16'hABCD, 16'h1234, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready",  start_ready, 1);
    chk("abort_valid",  res_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_carry",  carry_out, 0);
    chk("abort_ovf",    overflow, 0);
    repeat (NIBBLES + 2) begin
      @(posedge clk); #1;
      chk("abort_no_valid", res_valid, 0);
    end
    run_lit("after_abort", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      start_cmd(pick(), pick(), 1'($urandom));
      wait_res(n);
      finish_res($urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_addsub_seq.md
# nibble_addsub_seq

Multi-cycle add/subtract sequencer that time-shares one 4-bit ripple add/sub slice across a wide operand. A W-bit add or subtract (W = 4·NIBBLES) runs LSB nibble first, one nibble per clock, with the carry held in a register between cycles. It sits between a requesting unit (valid/ready command port) and a consumer (valid/ready result port), trading latency for a single 4-bit adder's worth of area.

## Interface
- NIBBLES, 4, number of 4-bit slices; operand width W = 4·NIBBLES; legal range ≥ 2
- clk  in  1  rising-edge clock; the block uses one clock.
- rst  in  1  reset, synchronous and active-high.
- start_valid  in  1  requester presents an operation
- start_ready  out  1  block can accept an operation; high only in IDLE
- op_a  in  W  minuend / addend A
- op_b  in  W  subtrahend / addend B
- op_sub  in  1  0 = A+B, 1 = A−B
- res_valid  out  1  result, carry_out and overflow valid
- res_ready  in  1  consumer accepts the result
- result  out  W  sum/difference, modulo 2^W
- carry_out  out  1  final carry; for subtract, 1 = no borrow (A ≥ B unsigned)
- overflow  out  1  two's-complement signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid, latch op_a, op_b, op_sub; idx←0; carry←op_sub; go to RUN.
- RUN: the slice computes nibble idx: a_nib + (b_nib XOR {4{sub}}) + carry. Write the sum into result nibble idx; carry←slice cout; idx←idx+1. When idx = NIBBLES−1, go to DONE instead.
- DONE: res_valid=1. result, carry_out and overflow are held stable. On res_ready, go to IDLE.
- carry_out = carry after the last nibble.
- Overflow, with a/b/r as the MSBs of the latched A, latched B and final result:
  - add: (a == b) && (r ≠ a)
  - sub: (a ≠ b) && (r ≠ a)
- Operand registers are captured only on accept. start_valid in RUN or DONE is ignored and nothing is latched.
- idx width is clog2(NIBBLES). idx never wraps past NIBBLES−1.
- The result register may change during RUN. Outputs are only defined while res_valid=1.

## Timing
- Reset values:
  - state=IDLE, idx=0, carry=0
  - result=0, carry_out=0, overflow=0, res_valid=0
  - start_ready=1 (the cycle after rst deasserts)
- start_ready and res_valid are decoded from the state register only, with no combinational path from inputs.
- Latency: if the command is accepted at edge k, res_valid=1 after edge k+NIBBLES.
- res_valid stays high until the edge where res_ready=1. The state is IDLE after that edge.
- Minimum issue interval is NIBBLES+2 cycles (RUN ×NIBBLES, DONE ≥1, IDLE 1).
- rst while in RUN or DONE aborts the operation at that edge:
  - all registers return to their reset values
  - no res_valid is produced for the aborted operation
- rst has priority over every handshake in the same cycle.

## Structure
- Package nibble_addsub_pkg holds:
  - NIBBLE_W = 4
  - the state enum {IDLE, RUN, DONE}
- Sub-module nibble_addsub_slice is the combinational 4-bit ripple add/sub:
  - inputs: a[3:0], b[3:0], inv, cin; outputs: sum[3:0], cout
  - it XORs b with inv internally
  - it has an explicit cin, separate from inv, so the carry can chain across cycles
- The sequencer instantiates exactly one slice.

## Test plan
Tests use NIBBLES=4.
- Add: 0x1234 + 0x0FCD, op_sub=0 -> result=0x2201, carry_out=0, overflow=0; res_valid exactly 4 edges after accept.
- Subtract with borrow: 0x0005 − 0x0007 -> result=0xFFFE, carry_out=0, overflow=0.
- Signed overflow:
  - 0x7FFF + 0x0001 -> 0x8000, overflow=1, carry_out=0.
  - 0x8000 − 0x0001 -> 0x7FFF, overflow=1, carry_out=1.
- Wrap-around: 0xFFFF + 0x0001 -> result=0x0000, carry_out=1, overflow=0. Also 0x1234 − 0x1234 -> 0x0000, carry_out=1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while driving start_valid=1 with new operands. Required:
  - res_valid and result stay constant
  - start_ready=0
  - the new operands are not latched
  - after res_ready=1, IDLE for one cycle, then the new command is accepted
- Reset mid-operation: assert rst for one cycle during the 2nd RUN cycle. Required:
  - next cycle is IDLE with start_ready=1, res_valid=0 and all outputs 0
  - a following 0x00FF + 0x0001 completes with 0x0100
